seq_detect_param: RTL

- Parametrised serial pattern detector; the next generation of the team's fixed "001" Mealy detector.
- Samples a 1-bit serial input on a prescaled sampling tick and compares the last PAT_LEN samples against a pattern that can be reloaded at run time.
- Selectable overlap/non-overlap mode, saturating match counter.
- Single clock domain: a clock-enable tick replaces the old derived-clock divider. Intended to drive board LEDs/switches or feed downstream logic.

---
 rtl/seq_detect_param.sv | 87 ++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: prescaled serial pattern detector with run-time pattern reload and saturating match count.
// Optional SEQ_INPUT_SYNC_EN adds a 2-flop input synchronizer for raw switch/button inputs.
module seq_detect_param #(
    parameter int                 PAT_LEN  = 3,
    parameter logic [PAT_LEN-1:0] PATTERN  = 3'b001,
    parameter int                 TICK_DIV = 50_000_000,
    parameter int                 CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in,
    input  logic                         overlap,
    input  logic [PAT_LEN-1:0]           pat_in,
    input  logic                         pat_load,
    input  logic                         cnt_clr,
    output logic                         tick,
    output logic                         match,
    output logic                         match_stb,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0] fill
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0]      div;
    logic [PAT_LEN-1:0] window, pat_reg, nw;
    logic [FW-1:0]      fill_nx;
    logic               in_s, hit, wrap;

`ifdef SEQ_INPUT_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], in};
    end
    assign in_s = sync[1];
`else
    assign in_s = in;
`endif

    // A load in the same cycle as a tick discards that tick's sample, so it can never hit.
    always_comb begin
        wrap    = div == DW'(TICK_DIV - 1);
        nw      = {window[PAT_LEN-2:0], in_s};
        hit     = tick && !pat_load && fill >= FW'(PAT_LEN - 1) && nw == pat_reg;
        fill_nx = (hit && !overlap) ? '0 : (fill == FW'(PAT_LEN)) ? fill : fill + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= wrap ? '0 : div + 1'b1;
            tick <= wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg   <= PATTERN;
            window    <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_stb <= 1'b0;
        end else if (pat_load) begin
            pat_reg   <= pat_in;
            window    <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_stb <= 1'b0;
        end else if (tick) begin
            window    <= nw;
            fill      <= fill_nx;
            match     <= hit;
            match_stb <= hit;
        end else begin
            match_stb <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         match_cnt <= '0;
        else if (cnt_clr)                  match_cnt <= '0;
        else if (hit && match_cnt != '1)   match_cnt <= match_cnt + 1'b1;
    end
endmodule
